// File: rtl/tile_ram_arbiter_pkg.sv
// Shared state encodings, access-length limits and helpers for the tile SRAM arbiter.
package tile_ram_arbiter_pkg;

  localparam int TRA_MIN_ACCESS_CYCLES     = 3;
  localparam int TRA_DEFAULT_ACCESS_CYCLES = 4;

  typedef enum logic [1:0] {
    TRA_IDLE   = 2'd0,
    TRA_ACCESS = 2'd1,
    TRA_TURN   = 2'd2
  } tra_state_e;

  typedef enum logic {
    TRA_OWN_CPU = 1'b0,
    TRA_OWN_VID = 1'b1
  } tra_owner_e;

  function automatic logic [15:0] tra_sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/tile_ram_arbiter_strobe_gen.sv
// sram_strobe_gen: decodes an access beat and direction into SRAM nOE/nWE and bus drive enable.
// Reusable by any controller that steps through fixed-length SRAM accesses.
module sram_strobe_gen #(
  parameter int C_ACCESS_CYCLES = 4,
  parameter int C_BEAT_W        = 3
) (
  input  logic                active_i,
  input  logic                we_i,
  input  logic [C_BEAT_W-1:0] beat_i,
  output logic                n_oe_o,
  output logic                n_we_o,
  output logic                data_oe_o
);

  localparam logic [C_BEAT_W-1:0] LAST_BEAT = C_BEAT_W'(C_ACCESS_CYCLES - 1);

  // First and last write beats keep nWE high for address setup and data hold.
  always_comb begin
    n_oe_o    = 1'b1;
    n_we_o    = 1'b1;
    data_oe_o = 1'b0;
    if (active_i) begin
      if (we_i) begin
        data_oe_o = 1'b1;
        n_we_o    = (beat_i == {C_BEAT_W{1'b0}}) || (beat_i == LAST_BEAT);
      end else begin
        n_oe_o = 1'b0;
      end
    end else begin
      n_oe_o = 1'b1;
    end
  end

endmodule

// File: rtl/tile_ram_arbiter.sv
// tile_ram_arbiter: shares one tile SRAM between video fetch (priority) and the CPU bus.
// Optional CPU stall counter is built when TILE_RAM_ARB_STATS_EN is defined.
module tile_ram_arbiter
  import tile_ram_arbiter_pkg::*;
#(
  parameter int C_ACCESS_CYCLES = TRA_DEFAULT_ACCESS_CYCLES,
  parameter int C_ADDR_WIDTH    = 13
) (
  input  logic                    i_Clk,
  input  logic                    i_nRst,
  input  logic                    i_VidReq,
  input  logic [C_ADDR_WIDTH-1:0] i_VidAddr,
  output logic                    o_VidValid,
  output logic [7:0]              o_VidData,
  output logic                    o_VidOverrun,
  input  logic                    i_CpuReq,
  input  logic                    i_CpuWe,
  input  logic [C_ADDR_WIDTH-1:0] i_CpuAddr,
  input  logic [7:0]              i_CpuData,
  output logic                    o_CpuAck,
  output logic [7:0]              o_CpuData,
  output logic [C_ADDR_WIDTH-1:0] o_SramAddr,
  output logic                    o_SramnOE,
  output logic                    o_SramnWE,
  output logic [7:0]              o_SramDataOut,
  output logic                    o_SramDataOe,
  input  logic [7:0]              i_SramData,
  output logic [15:0]             o_CpuStall
);

  localparam int                BEAT_W    = $clog2(C_ACCESS_CYCLES + 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(C_ACCESS_CYCLES - 1);

  if (C_ACCESS_CYCLES < TRA_MIN_ACCESS_CYCLES) begin : g_bad_cfg
    $error("C_ACCESS_CYCLES must be at least %0d", TRA_MIN_ACCESS_CYCLES);
  end

  tra_state_e              state_q, state_d;
  tra_owner_e              owner_q, owner_d;
  logic [BEAT_W-1:0]       beat_q, beat_d;
  logic                    we_q, we_d;
  logic [C_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]              dout_q, dout_d;
  logic [7:0]              cpu_data_q, cpu_data_d;
  logic [7:0]              vid_data_q, vid_data_d;
  logic                    cpu_ack_q, cpu_ack_d;
  logic                    vid_valid_q, vid_valid_d;
  logic                    vid_pend_q, vid_pend_d;
  logic [C_ADDR_WIDTH-1:0] vid_addr_q, vid_addr_d;
  logic                    overrun_q, overrun_d;
  logic                    n_oe_q, n_we_q, data_oe_q;
  logic                    n_oe_s, n_we_s, data_oe_s;
  logic                    vid_want_s, vid_grant_s;

  assign vid_want_s = vid_pend_q | i_VidReq;

  // Access sequencer: grant in IDLE, step beats in ACCESS, report results in TURN.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    beat_d      = beat_q;
    we_d        = we_q;
    addr_d      = addr_q;
    dout_d      = dout_q;
    cpu_data_d  = cpu_data_q;
    vid_data_d  = vid_data_q;
    cpu_ack_d   = 1'b0;
    vid_valid_d = 1'b0;
    vid_grant_s = 1'b0;
    case (state_q)
      TRA_IDLE: begin
        if (vid_want_s) begin
          vid_grant_s = 1'b1;
          state_d     = TRA_ACCESS;
          owner_d     = TRA_OWN_VID;
          beat_d      = {BEAT_W{1'b0}};
          we_d        = 1'b0;
          addr_d      = i_VidReq ? i_VidAddr : vid_addr_q;
        end else if (i_CpuReq) begin
          state_d = TRA_ACCESS;
          owner_d = TRA_OWN_CPU;
          beat_d  = {BEAT_W{1'b0}};
          we_d    = i_CpuWe;
          addr_d  = i_CpuAddr;
          dout_d  = i_CpuWe ? i_CpuData : dout_q;
        end else begin
          state_d = TRA_IDLE;
        end
      end
      TRA_ACCESS: begin
        if (beat_q == LAST_BEAT) begin
          state_d = TRA_TURN;
          beat_d  = {BEAT_W{1'b0}};
          if (owner_q == TRA_OWN_VID) begin
            vid_valid_d = 1'b1;
            vid_data_d  = i_SramData;
          end else begin
            cpu_ack_d  = 1'b1;
            cpu_data_d = we_q ? cpu_data_q : i_SramData;
          end
        end else begin
          beat_d = beat_q + BEAT_W'(1);
        end
      end
      TRA_TURN: state_d = TRA_IDLE;
      default:  state_d = TRA_IDLE;
    endcase
  end

  // A second request before the first is granted replaces it and flags the loss.
  always_comb begin
    vid_pend_d = vid_pend_q;
    vid_addr_d = vid_addr_q;
    if (i_VidReq && !vid_grant_s) begin
      vid_pend_d = 1'b1;
      vid_addr_d = i_VidAddr;
    end else if (vid_grant_s) begin
      vid_pend_d = 1'b0;
    end else begin
      vid_pend_d = vid_pend_q;
    end
    overrun_d = overrun_q | (i_VidReq & vid_pend_q);
  end

  sram_strobe_gen #(
    .C_ACCESS_CYCLES(C_ACCESS_CYCLES),
    .C_BEAT_W       (BEAT_W)
  ) u_strobe (
    .active_i (state_d == TRA_ACCESS),
    .we_i     (we_d),
    .beat_i   (beat_d),
    .n_oe_o   (n_oe_s),
    .n_we_o   (n_we_s),
    .data_oe_o(data_oe_s)
  );

  // State and output registers; reset parks every strobe inactive at once.
  always_ff @(posedge i_Clk or negedge i_nRst) begin
    if (!i_nRst) begin
      state_q     <= TRA_IDLE;
      owner_q     <= TRA_OWN_CPU;
      beat_q      <= {BEAT_W{1'b0}};
      we_q        <= 1'b0;
      addr_q      <= {C_ADDR_WIDTH{1'b0}};
      dout_q      <= 8'h00;
      cpu_data_q  <= 8'h00;
      vid_data_q  <= 8'h00;
      cpu_ack_q   <= 1'b0;
      vid_valid_q <= 1'b0;
      vid_pend_q  <= 1'b0;
      vid_addr_q  <= {C_ADDR_WIDTH{1'b0}};
      overrun_q   <= 1'b0;
      n_oe_q      <= 1'b1;
      n_we_q      <= 1'b1;
      data_oe_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      beat_q      <= beat_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      dout_q      <= dout_d;
      cpu_data_q  <= cpu_data_d;
      vid_data_q  <= vid_data_d;
      cpu_ack_q   <= cpu_ack_d;
      vid_valid_q <= vid_valid_d;
      vid_pend_q  <= vid_pend_d;
      vid_addr_q  <= vid_addr_d;
      overrun_q   <= overrun_d;
      n_oe_q      <= n_oe_s;
      n_we_q      <= n_we_s;
      data_oe_q   <= data_oe_s;
    end
  end

  assign o_VidValid    = vid_valid_q;
  assign o_VidData     = vid_data_q;
  assign o_VidOverrun  = overrun_q;
  assign o_CpuAck      = cpu_ack_q;
  assign o_CpuData     = cpu_data_q;
  assign o_SramAddr    = addr_q;
  assign o_SramnOE     = n_oe_q;
  assign o_SramnWE     = n_we_q;
  assign o_SramDataOut = dout_q;
  assign o_SramDataOe  = data_oe_q;

`ifdef TILE_RAM_ARB_STATS_EN
  logic [15:0] stall_q, stall_d;
  logic        stall_s;

  // CPU is stalled while video owns the SRAM or beats it in arbitration.
  always_comb begin
    stall_s = i_CpuReq & ((state_q == TRA_IDLE) ? vid_want_s : (owner_q == TRA_OWN_VID));
    stall_d = stall_s ? tra_sat_inc16(stall_q) : stall_q;
  end

  // Stall counter register.
  always_ff @(posedge i_Clk or negedge i_nRst) begin
    if (!i_nRst) begin
      stall_q <= 16'h0000;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign o_CpuStall = stall_q;
`else
  assign o_CpuStall = 16'h0000;
`endif

endmodule

// File: tb/tb_tile_ram_arbiter.sv
// Directed and randomised bench for tile_ram_arbiter with a behavioural CY6264 model.
module tb_tile_ram_arbiter;

  logic        clk, rst_n;
  logic        vid_req, vid_valid, vid_ovr;
  logic [12:0] vid_addr;
  logic [7:0]  vid_data;
  logic        cpu_req, cpu_we, cpu_ack;
  logic [12:0] cpu_addr;
  logic [7:0]  cpu_wdata, cpu_rdata;
  logic [12:0] sram_addr;
  logic        sram_noe, sram_nwe, sram_doe;
  logic [7:0]  sram_dout, sram_din;
  logic [15:0] cpu_stall;

  int n_chk = 0;
  int n_err = 0;
  int bus_viol = 0;

  tile_ram_arbiter dut (
    .i_Clk(clk), .i_nRst(rst_n),
    .i_VidReq(vid_req), .i_VidAddr(vid_addr),
    .o_VidValid(vid_valid), .o_VidData(vid_data), .o_VidOverrun(vid_ovr),
    .i_CpuReq(cpu_req), .i_CpuWe(cpu_we), .i_CpuAddr(cpu_addr), .i_CpuData(cpu_wdata),
    .o_CpuAck(cpu_ack), .o_CpuData(cpu_rdata),
    .o_SramAddr(sram_addr), .o_SramnOE(sram_noe), .o_SramnWE(sram_nwe),
    .o_SramDataOut(sram_dout), .o_SramDataOe(sram_doe), .i_SramData(sram_din),
    .o_CpuStall(cpu_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] init_val(input logic [12:0] a);
    return a[7:0] ^ {3'b101, a[12:8]};
  endfunction

  // SRAM model: untouched locations read back their power-on pattern.
  bit         sram_wr  [8192];
  logic [7:0] sram_mem [8192];
  always @(posedge clk) begin
    if (!sram_nwe && sram_doe) begin
      sram_mem[sram_addr] <= sram_dout;
      sram_wr[sram_addr]  <= 1'b1;
    end
  end
  always_comb begin
    if (sram_noe)               sram_din = 8'h00;
    else if (sram_wr[sram_addr]) sram_din = sram_mem[sram_addr];
    else                        sram_din = init_val(sram_addr);
  end

  always @(negedge clk) begin
    if (sram_doe && !sram_noe) bus_viol++;
  end

  // Reference memory, updated only when a CPU write is acknowledged.
  bit         ref_wr  [8192];
  logic [7:0] ref_mem [8192];
  function automatic logic [7:0] ref_rd(input logic [12:0] a);
    return ref_wr[a] ? ref_mem[a] : init_val(a);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_xfer(input logic we, input logic [12:0] a, input logic [7:0] d,
                          output logic [7:0] rd, output int lat, output int nwe_low);
    bit seen = 1'b0;
    lat = 0; nwe_low = 0; rd = 8'h00;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    for (int c = 1; c <= 50 && !seen; c++) begin
      tick();
      lat = c;
      if (!sram_nwe) nwe_low++;
      if (cpu_ack) begin
        seen = 1'b1;
        rd = cpu_rdata;
      end
    end
    cpu_req = 1'b0;
    if (!seen) check("cpu_ack_timeout", 32'(seen), 32'd1);
    if (we) begin
      ref_mem[a] = d;
      ref_wr[a]  = 1'b1;
    end
  endtask

  logic [7:0]  rd, rd_v, rd_c, old_v;
  logic [12:0] rv_addr;
  int          lat, nwe_low, vid_lat, cpu_lat, vid_cnt, ops, ack_cnt;
  bit          vid_seen, cpu_seen, cpu_busy, vid_busy, vid_nwe_low;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; vid_req = 1'b0; vid_addr = 13'h0000;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 13'h0000; cpu_wdata = 8'h00;
    #22;
    check("rst_noe",     32'(sram_noe), 32'd1);
    check("rst_nwe",     32'(sram_nwe), 32'd1);
    check("rst_doe",     32'(sram_doe), 32'd0);
    check("rst_addr",    32'(sram_addr), 32'd0);
    check("rst_dout",    32'(sram_dout), 32'd0);
    check("rst_strobes", 32'({cpu_ack, vid_valid, vid_ovr}), 32'd0);
    check("rst_data",    32'({cpu_rdata, vid_data}), 32'd0);
    check("rst_stall",   32'(cpu_stall), 32'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    tick();

    // CPU write then read-back at 0x0123
    cpu_xfer(1'b1, 13'h0123, 8'h5A, rd, lat, nwe_low);
    check("wr_lat", 32'(lat), 32'd5);
    check("wr_nwe_low_cycles", 32'(nwe_low), 32'd2);
    tick();
    cpu_xfer(1'b0, 13'h0123, 8'h00, rd, lat, nwe_low);
    check("rd_lat", 32'(lat), 32'd5);
    check("rd_data", 32'(rd), 32'h5A);
    check("rd_nwe_low_cycles", 32'(nwe_low), 32'd0);
    tick();

    // Uncontended video fetch of the top address
    vid_req = 1'b1; vid_addr = 13'h1FFF; vid_seen = 1'b0; vid_lat = 0; vid_nwe_low = 1'b0;
    for (int c = 1; c <= 30 && !vid_seen; c++) begin
      tick();
      vid_req = 1'b0;
      if (!sram_nwe) vid_nwe_low = 1'b1;
      if (vid_valid) begin vid_seen = 1'b1; vid_lat = c; rd_v = vid_data; end
    end
    check("vid_lat", 32'(vid_lat), 32'd5);
    check("vid_data", 32'(rd_v), 32'(init_val(13'h1FFF)));
    check("vid_nwe_stays_high", 32'(vid_nwe_low), 32'd0);
    tick();

    // Same-cycle video and CPU requests: video first, CPU one access later
    vid_req = 1'b1; vid_addr = 13'h0020;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0010;
    vid_seen = 1'b0; cpu_seen = 1'b0; vid_lat = 0; cpu_lat = 0;
    for (int c = 1; c <= 40 && !cpu_seen; c++) begin
      tick();
      vid_req = 1'b0;
      if (vid_valid && !vid_seen) begin vid_seen = 1'b1; vid_lat = c; rd_v = vid_data; end
      if (cpu_ack) begin cpu_seen = 1'b1; cpu_lat = c; rd_c = cpu_rdata; cpu_req = 1'b0; end
    end
    check("sim_vid_lat", 32'(vid_lat), 32'd5);
    check("sim_cpu_lat", 32'(cpu_lat), 32'd11);
    check("sim_vid_data", 32'(rd_v), 32'(ref_rd(13'h0020)));
    check("sim_cpu_data", 32'(rd_c), 32'(ref_rd(13'h0010)));
`ifdef TILE_RAM_ARB_STATS_EN
    check("sim_cpu_stall", 32'(cpu_stall), 32'd6);
`else
    check("sim_cpu_stall", 32'(cpu_stall), 32'd0);
`endif
    tick();

    // Two video pulses during a CPU write: only the second address is fetched
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h0300; cpu_wdata = 8'h77;
    vid_cnt = 0; cpu_seen = 1'b0; rd_v = 8'h00;
    for (int c = 1; c <= 40; c++) begin
      tick();
      vid_req  = (c == 2) || (c == 3);
      vid_addr = (c == 2) ? 13'h0100 : 13'h0200;
      if (cpu_ack) begin
        cpu_seen = 1'b1; cpu_req = 1'b0;
        ref_mem[13'h0300] = 8'h77; ref_wr[13'h0300] = 1'b1;
      end
      if (vid_valid) begin vid_cnt++; rd_v = vid_data; end
    end
    check("ovr_cpu_ack", 32'(cpu_seen), 32'd1);
    check("ovr_fetch_count", 32'(vid_cnt), 32'd1);
    check("ovr_fetch_data", 32'(rd_v), 32'(ref_rd(13'h0200)));
    check("ovr_flag", 32'(vid_ovr), 32'd1);
    tick();
    cpu_xfer(1'b0, 13'h0300, 8'h00, rd, lat, nwe_low);
    check("ovr_cpu_wr_data", 32'(rd), 32'h77);
    check("ovr_flag_sticky", 32'(vid_ovr), 32'd1);
    tick();

    // Random interleaved CPU and video traffic against the reference memory
    ops = 0; cpu_busy = 1'b0; vid_busy = 1'b0; rv_addr = 13'h0000;
    for (int c = 0; c < 40000 && (ops < 1000 || cpu_busy || vid_busy); c++) begin
      tick();
      vid_req = 1'b0;
      if (cpu_ack) begin
        if (!cpu_busy) check("rnd_spurious_ack", 32'd1, 32'd0);
        if (cpu_we) begin
          ref_mem[cpu_addr] = cpu_wdata; ref_wr[cpu_addr] = 1'b1;
        end else begin
          check("rnd_cpu_rd", 32'(cpu_rdata), 32'(ref_rd(cpu_addr)));
        end
        cpu_busy = 1'b0; cpu_req = 1'b0;
      end
      if (vid_valid) begin
        check("rnd_vid_rd", 32'(vid_data), 32'(ref_rd(rv_addr)));
        vid_busy = 1'b0;
      end
      if (ops < 1000) begin
        if (!vid_busy && $urandom_range(0, 5) == 0) begin
          vid_req = 1'b1; vid_addr = 13'h0400 + 13'($urandom_range(0, 255));
          rv_addr = vid_addr; vid_busy = 1'b1; ops++;
        end
        if (!cpu_busy && $urandom_range(0, 2) == 0) begin
          cpu_req = 1'b1; cpu_we = 1'($urandom_range(0, 1));
          cpu_addr = 13'h0400 + 13'($urandom_range(0, 255));
          cpu_wdata = 8'($urandom_range(0, 255)); cpu_busy = 1'b1; ops++;
        end
      end
    end
    check("rnd_complete", 32'(ops >= 1000 && !cpu_busy && !vid_busy), 32'd1);
    check("bus_exclusive", 32'(bus_viol), 32'd0);
    tick();

    // Reset asserted during write beat 2
    old_v = ref_rd(13'h0777);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h0777; cpu_wdata = 8'hC3;
    tick(); tick();
    check("mid_nwe_low_before_rst", 32'(sram_nwe), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_nwe", 32'(sram_nwe), 32'd1);
    check("mid_rst_doe", 32'(sram_doe), 32'd0);
    cpu_req = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    ack_cnt = 0;
    for (int c = 0; c < 15; c++) begin
      tick();
      if (cpu_ack || vid_valid) ack_cnt++;
    end
    check("mid_rst_no_ack", 32'(ack_cnt), 32'd0);
    check("mid_rst_ovr_clear", 32'(vid_ovr), 32'd0);
    cpu_xfer(1'b0, 13'h0777, 8'h00, rd, lat, nwe_low);
    check("mid_rst_mem_whole", 32'((rd == old_v) || (rd == 8'hC3)), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
